muldiv_unit: RTL and testbench

Iterative multiply/divide unit that serves HI/LO-class instructions issued by the execution stage. The execution stage initiates an operation with a one-cycle start pulse. The unit runs a 32-iteration shift-add multiply or restoring divide, then writes the 64-bit result into its own HI/LO registers. Busy/done handshakes let the hazard logic stall the pipeline until HI/LO are valid for MFHI/MFLO.

---
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / divide unit owning the HI/LO pair.
// A one-cycle Start_in in IDLE launches a 32-step shift-add multiply or
// restoring divide (PREP -> ITER x ITERS -> FIX); MTHI/MTLO write HI/LO
// directly at the accept edge without ever raising Busy_out.
//
// Ports:
//   Clk       rising-edge clock
//   Rst       asynchronous active-high reset
//   Start_in  one-cycle request, sampled only in IDLE
//   Op_in     000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//             100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
//   A_in      operand A (Rs): multiplicand, dividend, or MTHI/MTLO data
//   B_in      operand B (Rt): multiplier or divisor
//   Busy_out  operation in flight (registered)
//   Done_out  one-cycle pulse after HI/LO update
//   Hi_out    HI register
//   Lo_out    LO register
module muldiv_unit #(
  parameter int unsigned ITERS = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start_in,
  input  logic [2:0]  Op_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  output logic        Busy_out,
  output logic        Done_out,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out
);

  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [31:0]      a_q, b_q;     // operands as issued
  logic [31:0]      a_sh, b_sh;   // magnitudes, shifted during ITER
  logic             a_neg, b_neg;
  logic [63:0]      work;
  logic [CNT_W-1:0] cnt;

  logic        is_mt, accept, is_div, is_signed;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic        div_fits;
  logic [31:0] div_rem;
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;
  logic [63:0] fix_hilo;

  always_comb begin
    is_mt     = (Op_in[2:1] == 2'b11);
    accept    = (state == S_IDLE) && Start_in && !is_mt;
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV) ||
                (op_q == OP_MADD) || (op_q == OP_MSUB);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_PREP;
      S_PREP:  state_nxt = S_ITER;
      S_ITER:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // One iteration step of each algorithm.
  // Multiply: upper half accumulates the multiplicand, whole word shifts right,
  // so after ITERS steps work holds the full product.
  // Divide: partial remainder lives in work[63:32], quotient bits shift into
  // work[31:0]; bit 32 of the trial difference is the borrow (no restore).
  always_comb begin
    mul_sum   = {1'b0, work[63:32]} + {1'b0, (b_sh[0] ? a_sh : 32'd0)};
    div_trial = {work[63:32], a_sh[31]} - {1'b0, b_sh};
    div_fits  = !div_trial[32];
    div_rem   = div_fits ? div_trial[31:0] : {work[62:32], a_sh[31]};
  end

  // Sign correction and HI/LO result selection in FIX
  always_comb begin
    prod_s = (a_neg ^ b_neg) ? -work : work;
    quo_s  = (a_neg ^ b_neg) ? -work[31:0] : work[31:0];
    rem_s  = a_neg ? -work[63:32] : work[63:32];
    case (op_q)
      OP_MADD: fix_hilo = {Hi_out, Lo_out} + prod_s;
      OP_MSUB: fix_hilo = {Hi_out, Lo_out} - prod_s;
      OP_DIV, OP_DIVU: begin
        if (b_q == '0) fix_hilo = {a_q, 32'hFFFF_FFFF};
        else           fix_hilo = {rem_s, quo_s};
      end
      default: fix_hilo = prod_s;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      work     <= '0;
      cnt      <= '0;
      Busy_out <= 1'b0;
      Done_out <= 1'b0;
      Hi_out   <= '0;
      Lo_out   <= '0;
    end else begin
      Done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start_in) begin
            if (is_mt) begin
              if (Op_in[0]) Lo_out <= A_in;
              else          Hi_out <= A_in;
              Done_out <= 1'b1;
            end else begin
              op_q     <= op_e'(Op_in);
              a_q      <= A_in;
              b_q      <= B_in;
              Busy_out <= 1'b1;
            end
          end
        end
        S_PREP: begin
          a_neg <= is_signed && a_q[31];
          b_neg <= is_signed && b_q[31];
          a_sh  <= (is_signed && a_q[31]) ? -a_q : a_q;
          b_sh  <= (is_signed && b_q[31]) ? -b_q : b_q;
          work  <= '0;
          cnt   <= CNT_W'(ITERS - 1);
        end
        S_ITER: begin
          if (is_div) begin
            work <= {div_rem, work[30:0], div_fits};
            a_sh <= {a_sh[30:0], 1'b0};
          end else begin
            work <= {mul_sum, work[31:1]};
            b_sh <= {1'b0, b_sh[31:1]};
          end
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          {Hi_out, Lo_out} <= fix_hilo;
          Done_out         <= 1'b1;
          Busy_out         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations compared against an arithmetic model of HI/LO.
module tb_muldiv_unit;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                         DIVU = 3'b011, MADD = 3'b100, MSUB = 3'b101,
                         MTHI = 3'b110, MTLO = 3'b111;

  logic        clk, rst, start_in;
  logic [2:0]  op_in;
  logic [31:0] a_in, b_in;
  logic        busy_out, done_out;
  logic [31:0] hi_out, lo_out;

  int tests  = 0;
  int failed = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.ITERS(32)) dut (
    .Clk      (clk),
    .Rst      (rst),
    .Start_in (start_in),
    .Op_in    (op_in),
    .A_in     (a_in),
    .B_in     (b_in),
    .Busy_out (busy_out),
    .Done_out (done_out),
    .Hi_out   (hi_out),
    .Lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: new {HI,LO} from the architectural definition of each op
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
    int     sa, sb;
    longint sp;
    sa = int'(a);
    sb = int'(b);
    sp = longint'(sa) * longint'(sb);
    case (op)
      MULT:  return 64'(sp);
      MULTU: return {32'd0, a} * {32'd0, b};
      MADD:  return hilo + 64'(sp);
      MSUB:  return hilo - 64'(sp);
      DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MTHI:  return {a, hilo[31:0]};
      default: return {hilo[63:32], a};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation, follow it to completion and check the result.
  // inject: pulse a competing MULT start while busy (must be ignored).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    logic [63:0] exp;
    int cycles;
    bit held;
    @(negedge clk);
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    start_in = 1'b0; op_in = 3'($urandom); a_in = $urandom; b_in = $urandom;
    exp = ref_result(op, a, b, {m_hi, m_lo});
    if (op == MTHI || op == MTLO) begin
      check("mt_busy", 64'(busy_out), 64'd0);
      check("mt_done", 64'(done_out), 64'd1);
      check("mt_hilo", {hi_out, lo_out}, exp);
      {m_hi, m_lo} = exp;
      return;
    end
    check("done_low_at_accept", 64'(done_out), 64'd0);
    cycles = 0;
    held = 1'b1;
    while (busy_out && cycles < 100) begin
      if ({hi_out, lo_out} !== {m_hi, m_lo}) held = 1'b0;
      if (inject && cycles == 5) begin
        start_in = 1'b1; op_in = MULT; a_in = $urandom; b_in = $urandom;
      end
      if (inject && cycles == 7) start_in = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    start_in = 1'b0;
    check("busy_cycles", 64'(cycles), 64'd34);
    check("hilo_held_while_busy", 64'(held), 64'd1);
    check("done_pulse", 64'(done_out), 64'd1);
    check($sformatf("hi op%0d a=%h b=%h", op, a, b), 64'(hi_out), 64'(exp[63:32]));
    check($sformatf("lo op%0d a=%h b=%h", op, a, b), 64'(lo_out), 64'(exp[31:0]));
    {m_hi, m_lo} = exp;
  endtask

  initial begin
    rst = 1'b1; start_in = 1'b0; op_in = '0; a_in = '0; b_in = '0;
    m_hi = '0; m_lo = '0;
    #1;
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_done", 64'(done_out), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MADD, 32'd2, 32'd3, 1'b0);
    check("madd_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_hilo", {hi_out, lo_out}, {32'd2, 32'd14});
    run_op(DIVU, 32'h1234, 32'd0, 1'b0);
    check("divu_by_zero", {hi_out, lo_out}, {32'h1234, 32'hFFFF_FFFF});
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_overflow", {hi_out, lo_out}, {32'd0, 32'h8000_0000});
    run_op(MSUB, 32'hFFFF_FFFF, 32'd5, 1'b0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start_in = 1'b1; op_in = MTHI; a_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi_out), 64'h0000_0000_DEAD_BEEF);
    check("mthi_busy", 64'(busy_out), 64'd0);
    check("mthi_done", 64'(done_out), 64'd1);
    op_in = MTLO; a_in = 32'h0BAD_F00D;
    @(posedge clk); #1;
    start_in = 1'b0;
    check("mtlo_hilo", {hi_out, lo_out}, 64'hDEAD_BEEF_0BAD_F00D);
    check("mtlo_busy", 64'(busy_out), 64'd0);
    check("mtlo_done", 64'(done_out), 64'd1);
    @(posedge clk); #1;
    check("mt_done_clear", 64'(done_out), 64'd0);
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;

    // Start while busy is ignored
    run_op(MULT, 32'd5, 32'hFFFF_FFF7, 1'b1);
    check("ignored_start_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFD3);

    // Asynchronous reset mid-divide
    @(negedge clk);
    start_in = 1'b1; op_in = DIVU; a_in = 32'd1000; b_in = 32'd3;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy_out), 64'd0);
    check("midrst_done", 64'(done_out), 64'd0);
    check("midrst_hilo", {hi_out, lo_out}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(MULTU, 32'd6, 32'd7, 1'b0);
    check("post_rst_multu", {hi_out, lo_out}, 64'd42);

    // Randomized operations, back-to-back where the Done cycle allows
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
